// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: resolves execute-stage control transfers,
// flushes IF/ID and redirects fetch. Optional counters: YARP_BRANCH_PERF_EN.
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid_i,
  input  logic        ex_is_b_type_i,
  input  logic        ex_is_jal_i,
  input  logic        ex_is_jalr_i,
  input  logic        branch_taken_i,
  input  logic        pred_taken_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [31:0] ex_rs1_i,
  input  logic        redirect_ready_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [3:0]  flush_cnt;

  logic        actual;
  logic        need;
  logic        is_cti;
  logic        ev;
  logic        accept;
  logic        bad;
  logic [31:0] base;
  logic [31:0] sum;
  logic [31:0] target;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;

  always_comb begin
    is_cti  = ex_is_b_type_i | ex_is_jal_i | ex_is_jalr_i;
    actual  = ex_is_b_type_i ? branch_taken_i : 1'b1;
    base    = ex_is_jalr_i ? ex_rs1_i : ex_pc_i;
    sum     = base + ex_imm_i;
    target  = ex_is_jalr_i ? {sum[31:1], 1'b0} : sum;
    seq_pc  = ex_pc_i + 32'd4;
    next_pc = actual ? target : seq_pc;
    need    = (ex_is_b_type_i & (branch_taken_i != pred_taken_i))
            | (ex_is_jal_i & ~pred_taken_i)
            | ex_is_jalr_i;
    ev      = (state == IDLE) & ex_valid_i & is_cti;
    accept  = ev & need & ~next_pc[1];
    bad     = ev & need & next_pc[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      flush_cnt        <= '0;
      flush_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      stall_o          <= 1'b0;
      misalign_o       <= 1'b0;
      redirect_pc_o    <= RESET_PC;
    end else begin
      misalign_o <= bad;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state         <= FLUSH;
            flush_cnt     <= FLUSH_LOAD;
            flush_o       <= 1'b1;
            stall_o       <= 1'b1;
            redirect_pc_o <= next_pc;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state            <= REDIRECT;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            state            <= IDLE;
            redirect_valid_o <= 1'b0;
            stall_o          <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          flush_o          <= 1'b0;
          redirect_valid_o <= 1'b0;
          stall_o          <= 1'b0;
        end
      endcase
    end
  end

`ifdef YARP_BRANCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (ev) begin
      branch_cnt_o <= branch_cnt_o + 32'd1;
      if (need) begin
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
      end
    end
  end
`else
  assign branch_cnt_o  = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl.
// Counter expectations follow YARP_BRANCH_PERF_EN.
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        reset_n;
  logic        ex_valid_i;
  logic        ex_is_b_type_i;
  logic        ex_is_jal_i;
  logic        ex_is_jalr_i;
  logic        branch_taken_i;
  logic        pred_taken_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_imm_i;
  logic [31:0] ex_rs1_i;
  logic        redirect_ready_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic        stall_o;
  logic        misalign_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  int checks;
  int failures;

`ifdef YARP_BRANCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  branch_redirect_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ex_valid_i       (ex_valid_i),
    .ex_is_b_type_i   (ex_is_b_type_i),
    .ex_is_jal_i      (ex_is_jal_i),
    .ex_is_jalr_i     (ex_is_jalr_i),
    .branch_taken_i   (branch_taken_i),
    .pred_taken_i     (pred_taken_i),
    .ex_pc_i          (ex_pc_i),
    .ex_imm_i         (ex_imm_i),
    .ex_rs1_i         (ex_rs1_i),
    .redirect_ready_i (redirect_ready_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .flush_o          (flush_o),
    .stall_o          (stall_o),
    .misalign_o       (misalign_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // flush and redirect must never overlap
  always @(negedge clk) begin
    if (reset_n) begin
      chk("flush_rv_excl", 32'(flush_o & redirect_valid_o), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ex_valid_i     = 1'b0;
    ex_is_b_type_i = 1'b0;
    ex_is_jal_i    = 1'b0;
    ex_is_jalr_i   = 1'b0;
    branch_taken_i = 1'b0;
    pred_taken_i   = 1'b0;
    ex_pc_i        = '0;
    ex_imm_i       = '0;
    ex_rs1_i       = '0;
  endtask

  // kind: 0 = b-type, 1 = jal, 2 = jalr
  task automatic ev(input int kind, input logic tk, input logic pr,
                    input logic [31:0] pc, input logic [31:0] imm,
                    input logic [31:0] rs1);
    clr();
    ex_valid_i     = 1'b1;
    ex_is_b_type_i = (kind == 0);
    ex_is_jal_i    = (kind == 1);
    ex_is_jalr_i   = (kind == 2);
    branch_taken_i = tk;
    pred_taken_i   = pr;
    ex_pc_i        = pc;
    ex_imm_i       = imm;
    ex_rs1_i       = rs1;
  endtask

  // event already driven; clock it and walk through flush/redirect
  task automatic run_redirect(input string tag, input logic [31:0] pc);
    redirect_ready_i = 1'b1;
    tick();
    clr();
    chk({tag, "_f1"}, 32'(flush_o), 32'd1);
    tick();
    chk({tag, "_f2"}, 32'(flush_o), 32'd1);
    tick();
    chk({tag, "_rv"}, 32'(redirect_valid_o), 32'd1);
    chk({tag, "_pc"}, redirect_pc_o, pc);
    tick();
    chk({tag, "_done"}, 32'(stall_o | redirect_valid_o), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr();
    redirect_ready_i = 1'b0;
    reset_n = 1'b0;
    #12;
    chk("rst_rv", 32'(redirect_valid_o), 32'd0);
    chk("rst_fl", 32'(flush_o), 32'd0);
    chk("rst_st", 32'(stall_o), 32'd0);
    chk("rst_pc", redirect_pc_o, 32'h0);
    chk("rst_bc", branch_cnt_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // taken b-type mispredicted, ready high
    ev(0, 1'b1, 1'b0, 32'h100, 32'h20, 32'h0);
    redirect_ready_i = 1'b1;
    tick();
    clr();
    chk("b1_fl1", 32'(flush_o), 32'd1);
    chk("b1_st1", 32'(stall_o), 32'd1);
    chk("b1_rv1", 32'(redirect_valid_o), 32'd0);
    tick();
    chk("b1_fl2", 32'(flush_o), 32'd1);
    tick();
    chk("b1_fl3", 32'(flush_o), 32'd0);
    chk("b1_rv3", 32'(redirect_valid_o), 32'd1);
    chk("b1_pc3", redirect_pc_o, 32'h120);
    chk("b1_st3", 32'(stall_o), 32'd1);
    tick();
    chk("b1_rv4", 32'(redirect_valid_o), 32'd0);
    chk("b1_st4", 32'(stall_o), 32'd0);

    // not-taken mispredicted, fetch back-pressure
    ev(0, 1'b0, 1'b1, 32'h100, 32'h20, 32'h0);
    redirect_ready_i = 1'b0;
    tick();
    clr();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("b2_rv", 32'(redirect_valid_o), 32'd1);
      chk("b2_pc", redirect_pc_o, 32'h104);
      chk("b2_st", 32'(stall_o), 32'd1);
      if (i < 2) tick();
    end
    redirect_ready_i = 1'b1;
    tick();
    chk("b2_rv_end", 32'(redirect_valid_o), 32'd0);
    chk("b2_st_end", 32'(stall_o), 32'd0);

    // jalr to misaligned target
    ev(2, 1'b0, 1'b0, 32'h300, 32'h0, 32'h203);
    tick();
    clr();
    chk("ma_pulse", 32'(misalign_o), 32'd1);
    chk("ma_fl", 32'(flush_o), 32'd0);
    chk("ma_st", 32'(stall_o), 32'd0);
    tick();
    chk("ma_end", 32'(misalign_o), 32'd0);
    chk("ma_rv", 32'(redirect_valid_o), 32'd0);

    // jalr clears bit 0
    ev(2, 1'b0, 1'b0, 32'h300, 32'h0, 32'h201);
    run_redirect("jr", 32'h200);

    // wrap-around target, second event during flush ignored
    ev(0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0);
    tick();
    ev(1, 1'b1, 1'b0, 32'h40, 32'h8, 32'h0);
    chk("wr_fl1", 32'(flush_o), 32'd1);
    tick();
    clr();
    chk("wr_fl2", 32'(flush_o), 32'd1);
    tick();
    chk("wr_pc", redirect_pc_o, 32'h0000_0010);
    tick();
    chk("wr_idle", 32'(stall_o), 32'd0);
    tick();
    chk("wr_nofl", 32'(flush_o), 32'd0);
    chk("wr_bc", branch_cnt_o, PERF ? 32'd5 : 32'd0);
    chk("wr_mc", mispred_cnt_o, PERF ? 32'd5 : 32'd0);

    // reset in second flush cycle
    ev(0, 1'b1, 1'b0, 32'h4F0, 32'h10, 32'h0);
    tick();
    clr();
    tick();
    chk("rf_fl", 32'(flush_o), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rf_fl0", 32'(flush_o), 32'd0);
    chk("rf_st0", 32'(stall_o), 32'd0);
    chk("rf_rv0", 32'(redirect_valid_o), 32'd0);
    chk("rf_pc0", redirect_pc_o, 32'h0);
    chk("rf_bc0", branch_cnt_o, 32'd0);
    chk("rf_mc0", mispred_cnt_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // five branches, two mispredicted
    ev(0, 1'b1, 1'b1, 32'h600, 32'h40, 32'h0);
    tick();
    clr();
    chk("ok1_fl", 32'(flush_o | stall_o), 32'd0);
    tick();
    chk("ok1_rv", 32'(redirect_valid_o), 32'd0);
    chk("ok1_pc", redirect_pc_o, 32'h0);
    ev(1, 1'b0, 1'b1, 32'h620, 32'h40, 32'h0);
    tick();
    clr();
    chk("ok2_fl", 32'(flush_o), 32'd0);
    ev(0, 1'b0, 1'b1, 32'h700, 32'h40, 32'h0);
    run_redirect("mp1", 32'h704);
    ev(0, 1'b0, 1'b0, 32'h720, 32'h40, 32'h0);
    tick();
    clr();
    chk("ok3_fl", 32'(flush_o), 32'd0);
    ev(1, 1'b0, 1'b0, 32'h800, 32'h100, 32'h0);
    run_redirect("mp2", 32'h900);
    chk("pf_bc", branch_cnt_o, PERF ? 32'd5 : 32'd0);
    chk("pf_mc", mispred_cnt_o, PERF ? 32'd2 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles flush_o is held per redirect (legal range 1..15).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, value of redirect_pc_o out of reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset is asynchronous and active-low.
REQ-005 ex_valid_i  input  1  execute-stage control-transfer result valid this cycle.
REQ-006 ex_is_b_type_i, ex_is_jal_i, ex_is_jalr_i  input  1 each  instruction class; at most one high.
REQ-007 branch_taken_i  input  1  branch outcome from branch_control.
REQ-008 pred_taken_i  input  1  fetch-stage prediction carried with the instruction.
REQ-009 ex_pc_i, ex_imm_i, ex_rs1_i  input  32 each  instruction PC, sign-extended immediate, rs1 value.
REQ-010 redirect_ready_i  input  1  fetch accepts the redirect.
REQ-011 redirect_valid_o  output  1  redirect request to fetch.
REQ-012 redirect_pc_o  output  32  redirect target, stable while redirect_valid_o high.
REQ-013 flush_o  output  1  kill younger instructions in IF/ID.
REQ-014 stall_o  output  1  hold execute stage; high whenever state is not IDLE.
REQ-015 misalign_o  output  1  one-cycle pulse for a misaligned taken target.
REQ-016 branch_cnt_o, mispred_cnt_o  output  32 each  performance counters (see Configuration).

Function
REQ-017 Actual-taken: b-type = branch_taken_i; jal/jalr = 1; other classes are never evaluated.
REQ-018 Taken target: b-type and jal = ex_pc_i + ex_imm_i; jalr = (ex_rs1_i + ex_imm_i) with bit 0 cleared; all sums are modulo 2^32 (wrap, no flag).
REQ-019 Redirect required: b-type with actual != pred_taken_i; jal with pred_taken_i = 0; jalr always.
REQ-020 Redirect PC: target when actual-taken, else ex_pc_i + 4 (modulo 2^32).
REQ-021 FSM states: IDLE, FLUSH, REDIRECT.
REQ-022 IDLE: ex_valid_i high, redirect required, and redirect PC bit 1 = 0 -> latch redirect PC, go to FLUSH next cycle; otherwise stay in IDLE.
REQ-023 IDLE: ex_valid_i high, redirect required, and redirect PC bit 1 = 1 -> misalign_o pulses next cycle; no flush or redirect; stay in IDLE.
REQ-024 FLUSH: flush_o = 1 for exactly FLUSH_CYCLES cycles via a down-counter, then REDIRECT.
REQ-025 REDIRECT: redirect_valid_o = 1 with the latched PC; when redirect_ready_i = 1 on the same edge, go to IDLE; otherwise hold.
REQ-026 Latency: accepting event at edge N -> flush_o high in cycles N+1..N+FLUSH_CYCLES; redirect_valid_o high from N+FLUSH_CYCLES+1.
REQ-027 ex_valid_i while not in IDLE is ignored, with no counter update.
REQ-028 redirect_ready_i outside REDIRECT has no effect.
REQ-029 All outputs are registered; flush_o and redirect_valid_o are never high together.

Reset
REQ-030 reset_n low, asynchronous, at any time including mid-FLUSH or mid-REDIRECT: state = IDLE, flush counter = 0.
REQ-031 Reset values: redirect_valid_o, flush_o, stall_o and misalign_o = 0; redirect_pc_o = RESET_PC; counters = 0.
REQ-032 The first event is accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-033 Macro YARP_BRANCH_PERF_EN defined: branch_cnt_o increments on each accepted IDLE event; mispred_cnt_o increments on each event that requires a redirect (REQ-019). Both wrap at 2^32.
REQ-034 Macro YARP_BRANCH_PERF_EN undefined: both counter ports remain and are tied to 0; no counter flops are synthesized.

Verification
REQ-035 b-type, pc=0x100, imm=0x20, taken=1, pred=0, ready=1 -> flush_o for 2 cycles, then redirect_pc_o=0x120 for 1 cycle, then IDLE.
REQ-036 b-type, pc=0x100, taken=0, pred=1, ready held 0 for 3 cycles -> redirect_pc_o=0x104 is held stable and stall_o stays high until ready.
REQ-037 jalr, rs1=0x203, imm=0 -> target 0x202 (bit 1 set) -> misalign_o pulses once, no flush; jalr, rs1=0x201 -> redirect to 0x200.
REQ-038 b-type, pc=0xFFFF_FFF0, imm=0x20, taken=1, pred=0 -> redirect_pc_o=0x0000_0010; a second ex_valid_i during FLUSH is ignored.
REQ-039 reset_n asserted in the 2nd FLUSH cycle -> all outputs reach reset values immediately; the next correctly predicted branch produces no redirect.
REQ-040 With YARP_BRANCH_PERF_EN, 5 branches of which 2 mispredicted -> branch_cnt_o=5, mispred_cnt_o=2; without the macro -> both read 0.
